p4_ctrl_axil_master: RTL and testbench
======================================

# p4_ctrl_axil_master

AXI4-Lite initiator that executes single control-plane register accesses against the P4 router's `control` slave port (Vitis Net P4 table and register space). Accepts one command at a time on a valid/ready command channel, runs the matching AXI4-Lite write or read transaction, and returns one response per command. A timeout guards against a hung slave, and a saturating error counter records failed accesses.

## Interface
- `ADDR_WIDTH`, default 15: byte address width, matching the VNP4 control address space. Data width is fixed at 32 bits and strobe width at 4 bits.
- `TIMEOUT_CYCLES`, default 1024: cycles allowed from command acceptance to the B or R handshake. Must be at least 4; elaboration check.
- `clk_ifc`, input, Clock_int: single clock for all logic.
- `areset_n_ifc`, input, Reset_int: one clock; reset is asynchronous and active-low.
- `cmd_valid`, input, 1: command present.
- `cmd_ready`, output, 1: command accepted when high with `cmd_valid`.
- `cmd_write`, input, 1: 1 selects write, 0 selects read.
- `cmd_addr`, input, ADDR_WIDTH: byte address; bits [1:0] are forced to 0 on the bus.
- `cmd_wdata`, input, 32: write data.
- `cmd_wstrb`, input, 4: write strobes.
- `rsp_valid`, output, 1: response present.
- `rsp_ready`, input, 1: response consumed.
- `rsp_rdata`, output, 32: read data; 0 for writes and timeouts.
- `rsp_resp`, output, 2: captured BRESP or RRESP; 2'b10 on timeout.
- `rsp_timeout`, output, 1: the command timed out.
- `control`, AXI4Lite_int.Master: AW, W, B, AR and R channels.
- `busy`, output, 1: high in every state other than IDLE.
- `err_count`, output, 16: saturating count of responses with resp ≠ 2'b00 or timeout = 1.

## Operation
- States:
  - IDLE
  - WR_ADDR: AW and/or W still pending.
  - WR_RESP
  - RD_ADDR
  - RD_DATA
  - RSP
  - DRAIN
- IDLE:
  - `cmd_ready` = 1.
  - On handshake, latch the command.
  - Go to WR_ADDR if `cmd_write`, otherwise RD_ADDR.
- WR_ADDR:
  - `awvalid` and `wvalid` assert together on entry.
  - Each drops independently after its own handshake.
  - When both have completed, go to WR_RESP.
  - AW and W may complete in either order or in the same cycle.
- WR_RESP: `bready` = 1. On the B handshake, capture `bresp` and go to RSP.
- RD_ADDR: `arvalid` = 1 until the AR handshake, then go to RD_DATA.
- RD_DATA: `rready` = 1. On the R handshake, capture `rdata` and `rresp`, then go to RSP.
- RSP:
  - `rsp_valid` = 1, with all fields stable until `rsp_ready`.
  - On handshake, go to IDLE, or to DRAIN if the timeout flag is set and the bus transaction is still open.
- Timeout:
  - An 8+log2(TIMEOUT_CYCLES)-bit counter clears on command accept.
  - It increments each cycle in WR_ADDR, WR_RESP, RD_ADDR and RD_DATA.
  - On reaching TIMEOUT_CYCLES − 1 without the closing handshake, go to RSP with:
    - `rsp_timeout` = 1
    - `rsp_resp` = 2'b10
    - `rsp_rdata` = 0
  - Pending AXI valids and readies keep their values.
- DRAIN:
  - Keep driving the outstanding channel signals until the transaction closes (B or R handshake), then go to IDLE.
  - The late response is discarded.
  - `cmd_ready` = 0 throughout.
- `err_count` increments on the RSP handshake when `rsp_resp` ≠ 0 or `rsp_timeout` = 1, and saturates at 16'hFFFF.
- `awprot` and `arprot` are 3'b000.

## Timing
- Reset values:
  - `cmd_ready` = 0; it rises on the first clock edge after deassertion.
  - All AXI valids and readies = 0.
  - `rsp_valid` = 0 and all `rsp_*` fields = 0.
  - `busy` = 0; `err_count` = 0.
  - State = IDLE.
- Reset asserted mid-transaction immediately drops every valid and ready, abandons the transaction, and clears the counters.
- All outputs are registered, and no output depends combinationally on an input.
- Write path with a zero-wait slave:
  - Cycle 0: command accept.
  - Cycle 1: `awvalid`/`wvalid` high, handshake.
  - Cycle 2: `bready` high, B handshake.
  - Cycle 3: `rsp_valid`.
  - Minimum latency is 3 cycles.
- Read path with a zero-wait slave:
  - Cycle 0: command accept.
  - Cycle 1: AR handshake.
  - Cycle 2: R handshake.
  - Cycle 3: `rsp_valid`.
  - Minimum latency is 3 cycles.
- Throughput is one command per (latency + 1) cycles: `cmd_ready` returns in the cycle after the RSP handshake.
- AXI valids never drop before their handshake. Address and data are stable while valid is high.
- A timeout and a closing handshake in the same cycle: the handshake wins, giving a normal response with no DRAIN.

## Test plan
- Write, zero-wait slave:
  - Stimulus: addr 0x0104, data 0xDEADBEEF, wstrb 4'hF.
  - Response: bus awaddr 0x0104 / wdata 0xDEADBEEF, then rsp_valid at cycle 3 with resp 0, rdata 0 and timeout 0.
- Read, 5-cycle R delay:
  - Stimulus: the slave returns 0x12345678 with RRESP 2'b00.
  - Response: rsp_rdata 0x12345678, and rsp_valid at cycle 8.
- AW handshake at cycle 1 and W handshake at cycle 4:
  - `awvalid` low from cycle 2 while `wvalid` stays high.
  - `bready` not asserted before cycle 5.
- Slave silent with TIMEOUT_CYCLES = 16:
  - rsp_timeout = 1 and resp 2'b10 after 16 cycles; err_count goes to 1.
  - The late BVALID at cycle 40 is drained, then cmd_ready returns.
- SLVERR read:
  - rsp_resp 2'b10, rsp_timeout 0, err_count increments.
  - rsp_ready held low for 10 cycles: fields stay stable.
- Async reset asserted in WR_RESP:
  - All valids, readies and rsp_valid go to 0 without a clock edge.
  - After release, a new read completes normally.

Source files
------------

// File: rtl/p4_ctrl_axil_master.sv
// AXI4-Lite initiator for single control-plane register accesses on the P4 router control port.
// One command in flight; each command gets one response, with a timeout and a saturating error count.
module p4_ctrl_axil_master #(
  parameter int unsigned ADDR_WIDTH     = 15,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_ifc,
  input  logic                  areset_n_ifc,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] control_awaddr,
  output logic [2:0]            control_awprot,
  output logic                  control_awvalid,
  input  logic                  control_awready,
  output logic [31:0]           control_wdata,
  output logic [3:0]            control_wstrb,
  output logic                  control_wvalid,
  input  logic                  control_wready,
  input  logic [1:0]            control_bresp,
  input  logic                  control_bvalid,
  output logic                  control_bready,
  output logic [ADDR_WIDTH-1:0] control_araddr,
  output logic [2:0]            control_arprot,
  output logic                  control_arvalid,
  input  logic                  control_arready,
  input  logic [31:0]           control_rdata,
  input  logic [1:0]            control_rresp,
  input  logic                  control_rvalid,
  output logic                  control_rready,
  output logic                  busy,
  output logic [15:0]           err_count
);

  localparam int unsigned CntW = 8 + $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < 4) begin : gen_timeout_check
    $error("TIMEOUT_CYCLES must be at least 4");
  end

  typedef enum logic [2:0] {
    StIdle,
    StWrAddr,
    StWrResp,
    StRdAddr,
    StRdData,
    StRsp,
    StDrain
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic [15:0]           err_count_q, err_count_d;
  logic                  cmd_ready_q, rsp_valid_q, busy_q;

  logic cmd_accept, aw_w_done, b_hs, ar_hs, r_hs, timed_out, open_d;
  logic unused_addr_lsb;

  assign unused_addr_lsb = ^cmd_addr[1:0];

  assign cmd_accept = cmd_valid & cmd_ready_q;
  assign b_hs       = bready_q & control_bvalid;
  assign ar_hs      = arvalid_q & control_arready;
  assign r_hs       = rready_q & control_rvalid;
  assign timed_out  = (cnt_q == TimeoutLast);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    err_count_d   = err_count_q;

    // Channel progress runs independently of the main state so a timed-out access still closes.
    if (awvalid_q && control_awready) awvalid_d = 1'b0;
    if (wvalid_q && control_wready)   wvalid_d  = 1'b0;
    aw_w_done = (awvalid_q | wvalid_q) & ~awvalid_d & ~wvalid_d;
    if (b_hs)      bready_d = 1'b0;
    if (aw_w_done) bready_d = 1'b1;
    if (ar_hs) begin
      arvalid_d = 1'b0;
      rready_d  = 1'b1;
    end
    if (r_hs) rready_d = 1'b0;
    open_d = awvalid_d | wvalid_d | bready_d | arvalid_d | rready_d;

    unique case (state_q)
      StIdle: begin
        if (cmd_accept) begin
          addr_d = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
          cnt_d  = '0;
          if (cmd_write) begin
            state_d   = StWrAddr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = StRdAddr;
            arvalid_d = 1'b1;
          end
        end
      end
      StWrAddr, StWrResp, StRdAddr, StRdData: begin
        cnt_d = cnt_q + CntW'(1);
        if (state_q == StWrAddr && aw_w_done) begin
          state_d = StWrResp;
        end else if (state_q == StRdAddr && ar_hs) begin
          state_d = StRdData;
        end else if (state_q == StWrResp && b_hs) begin
          state_d       = StRsp;
          rsp_rdata_d   = '0;
          rsp_resp_d    = control_bresp;
          rsp_timeout_d = 1'b0;
        end else if (state_q == StRdData && r_hs) begin
          state_d       = StRsp;
          rsp_rdata_d   = control_rdata;
          rsp_resp_d    = control_rresp;
          rsp_timeout_d = 1'b0;
        end else if (timed_out) begin
          state_d       = StRsp;
          rsp_rdata_d   = '0;
          rsp_resp_d    = 2'b10;
          rsp_timeout_d = 1'b1;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          if ((rsp_resp_q != 2'b00 || rsp_timeout_q) && err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
          end
          state_d = (rsp_timeout_q && open_d) ? StDrain : StIdle;
        end
      end
      StDrain: begin
        if (!open_d) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_ifc or negedge areset_n_ifc) begin
    if (!areset_n_ifc) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
      err_count_q   <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      err_count_q   <= err_count_d;
      cmd_ready_q   <= (state_d == StIdle);
      rsp_valid_q   <= (state_d == StRsp);
      busy_q        <= (state_d != StIdle);
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign rsp_resp        = rsp_resp_q;
  assign rsp_timeout     = rsp_timeout_q;
  assign control_awaddr  = addr_q;
  assign control_awprot  = 3'b000;
  assign control_awvalid = awvalid_q;
  assign control_wdata   = wdata_q;
  assign control_wstrb   = wstrb_q;
  assign control_wvalid  = wvalid_q;
  assign control_bready  = bready_q;
  assign control_araddr  = addr_q;
  assign control_arprot  = 3'b000;
  assign control_arvalid = arvalid_q;
  assign control_rready  = rready_q;
  assign busy            = busy_q;
  assign err_count       = err_count_q;

endmodule

// File: tb/tb_p4_ctrl_axil_master.sv
// Directed bench for p4_ctrl_axil_master: zero-wait and stalled writes/reads, timeout with drain,
// SLVERR, timeout-vs-handshake tie, and asynchronous reset mid-transaction.
module tb_p4_ctrl_axil_master;

  logic        clk_ifc = 1'b0;
  logic        areset_n_ifc;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [14:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic [14:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        busy;
  logic [15:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_ifc = ~clk_ifc;

  p4_ctrl_axil_master #(
    .ADDR_WIDTH    (15),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_ifc        (clk_ifc),
    .areset_n_ifc   (areset_n_ifc),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .cmd_wstrb      (cmd_wstrb),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_resp       (rsp_resp),
    .rsp_timeout    (rsp_timeout),
    .control_awaddr (awaddr),
    .control_awprot (awprot),
    .control_awvalid(awvalid),
    .control_awready(awready),
    .control_wdata  (wdata),
    .control_wstrb  (wstrb),
    .control_wvalid (wvalid),
    .control_wready (wready),
    .control_bresp  (bresp),
    .control_bvalid (bvalid),
    .control_bready (bready),
    .control_araddr (araddr),
    .control_arprot (arprot),
    .control_arvalid(arvalid),
    .control_arready(arready),
    .control_rdata  (rdata),
    .control_rresp  (rresp),
    .control_rvalid (rvalid),
    .control_rready (rready),
    .busy           (busy),
    .err_count      (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ifc);
    #1;
  endtask

  // Presents a command in cycle 0 and returns in cycle 1.
  task automatic send_cmd(input logic wr, input logic [14:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100000");
    $fatal(1);
  end

  initial begin
    areset_n_ifc = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_valids", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    @(negedge clk_ifc);
    areset_n_ifc = 1'b1;
    #1;
    chk("cmd_ready_before_edge", 32'(cmd_ready), 32'd0);
    tick();

    // Write, zero-wait slave
    awready = 1'b1; wready = 1'b1;
    send_cmd(1'b1, 15'h0104, 32'hDEADBEEF, 4'hF);
    chk("w1_c1_aw_w", 32'({awvalid, wvalid}), 32'd3);
    chk("w1_awaddr", 32'(awaddr), 32'h0104);
    chk("w1_wdata", wdata, 32'hDEADBEEF);
    chk("w1_wstrb", 32'(wstrb), 32'hF);
    chk("w1_prot", 32'({awprot, arprot}), 32'd0);
    chk("w1_busy_cmdrdy", 32'({busy, cmd_ready}), 32'b10);
    tick();
    chk("w1_c2", 32'({awvalid, wvalid, bready, rsp_valid}), 32'b0010);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    chk("w1_c3_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp, bready}), 32'b10000);
    chk("w1_rdata", rsp_rdata, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("w1_c4", 32'({rsp_valid, cmd_ready, busy}), 32'b010);
    chk("w1_err", 32'(err_count), 32'd0);

    // Read, 5-cycle R delay; low address bits forced to zero
    arready = 1'b1;
    send_cmd(1'b0, 15'h0203, 32'h0, 4'h0);
    chk("r1_c1_ar", 32'({arvalid, awvalid, wvalid}), 32'b100);
    chk("r1_araddr", 32'(araddr), 32'h0200);
    tick();
    chk("r1_c2", 32'({arvalid, rready}), 32'b01);
    for (int c = 3; c <= 7; c++) tick();
    chk("r1_c7", 32'({rready, rsp_valid}), 32'b10);
    rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b00;
    tick();
    rvalid = 1'b0; rdata = 32'h0;
    chk("r1_c8_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp, rready}), 32'b10000);
    chk("r1_rdata", rsp_rdata, 32'h12345678);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("r1_c9_cmdrdy", 32'(cmd_ready), 32'd1);

    // AW at cycle 1, W at cycle 4
    awready = 1'b1; wready = 1'b0;
    send_cmd(1'b1, 15'h0010, 32'hA5A50001, 4'h3);
    chk("ow_c1", 32'({awvalid, wvalid}), 32'b11);
    tick();
    awready = 1'b0;
    chk("ow_c2", 32'({awvalid, wvalid, bready}), 32'b010);
    tick();
    chk("ow_c3", 32'({awvalid, wvalid, bready}), 32'b010);
    tick();
    wready = 1'b1;
    chk("ow_c4", 32'({awvalid, wvalid, bready}), 32'b010);
    chk("ow_wstrb", 32'(wstrb), 32'h3);
    tick();
    wready = 1'b0;
    chk("ow_c5", 32'({awvalid, wvalid, bready}), 32'b001);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    chk("ow_c6_rsp", 32'({rsp_valid, rsp_resp}), 32'b100);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("ow_err", 32'(err_count), 32'd0);

    // Silent slave: timeout, then drain a late B at cycle 40
    send_cmd(1'b1, 15'h0400, 32'h11112222, 4'hF);
    for (int c = 2; c <= 16; c++) tick();
    chk("to_c16", 32'({rsp_valid, awvalid, wvalid}), 32'b011);
    tick();
    chk("to_c17_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'b1110);
    chk("to_rdata", rsp_rdata, 32'd0);
    chk("to_valids_kept", 32'({awvalid, wvalid}), 32'b11);
    chk("to_err_pre", 32'(err_count), 32'd0);
    rsp_ready = 1'b1; awready = 1'b1; wready = 1'b1;
    tick();
    rsp_ready = 1'b0; awready = 1'b0; wready = 1'b0;
    chk("to_err", 32'(err_count), 32'd1);
    chk("to_c18", 32'({rsp_valid, cmd_ready, busy, awvalid, bready}), 32'b00101);
    for (int c = 19; c <= 40; c++) tick();
    chk("to_c40", 32'({bready, cmd_ready}), 32'b10);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    chk("to_c41", 32'({cmd_ready, bready, busy, rsp_valid}), 32'b1000);
    chk("to_err_post", 32'(err_count), 32'd1);

    // SLVERR read with a stalled response consumer
    arready = 1'b1;
    send_cmd(1'b0, 15'h0008, 32'h0, 4'h0);
    tick();
    rvalid = 1'b1; rdata = 32'hBAD00BAD; rresp = 2'b10;
    tick();
    rvalid = 1'b0;
    chk("se_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'b1010);
    for (int i = 0; i < 10; i++) begin
      rdata = 32'(i) * 32'h01010101; rresp = 2'(i);
      tick();
      chk("se_hold", 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'b1010);
      chk("se_hold_rdata", rsp_rdata, 32'hBAD00BAD);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("se_err", 32'(err_count), 32'd2);

    // B handshake in the same cycle as the timeout: normal response, no drain
    awready = 1'b1; wready = 1'b1;
    send_cmd(1'b1, 15'h0020, 32'h00C0FFEE, 4'h1);
    for (int c = 2; c <= 16; c++) tick();
    chk("tie_c16", 32'({bready, rsp_valid}), 32'b10);
    bvalid = 1'b1; bresp = 2'b00;
    tick();
    bvalid = 1'b0;
    chk("tie_c17", 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'b1000);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("tie_c18", 32'({cmd_ready, busy}), 32'b10);
    chk("tie_err", 32'(err_count), 32'd2);

    // Asynchronous reset while in WR_RESP
    send_cmd(1'b1, 15'h0030, 32'h55AA55AA, 4'hF);
    tick();
    chk("ar_c2_bready", 32'(bready), 32'd1);
    #2;
    areset_n_ifc = 1'b0;
    #1;
    chk("ar_valids", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 32'd0);
    chk("ar_busy_cmdrdy", 32'({busy, cmd_ready}), 32'd0);
    chk("ar_err", 32'(err_count), 32'd0);
    @(negedge clk_ifc);
    areset_n_ifc = 1'b1;
    tick();
    arready = 1'b1;
    send_cmd(1'b0, 15'h0300, 32'h0, 4'h0);
    chk("ar_rd_c1", 32'(arvalid), 32'd1);
    tick();
    rvalid = 1'b1; rdata = 32'hCAFEF00D; rresp = 2'b00;
    tick();
    rvalid = 1'b0;
    chk("ar_rd_rsp", 32'({rsp_valid, rsp_timeout, rsp_resp}), 32'b1000);
    chk("ar_rd_rdata", rsp_rdata, 32'hCAFEF00D);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("ar_rd_done", 32'({cmd_ready, busy}), 32'b10);
    chk("ar_rd_err", 32'(err_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
